// File: rtl/cla_pkg.sv
// -----------------------------------------------------------------------------
// cla_pkg
// Shared definitions for the sequential carry-lookahead add/subtract unit:
//   - state_t       : controller states (IDLE, RUN)
//   - cnt_width()   : width of the chunk counter for a given chunk count
//   - sat_max_pos() : most positive two's-complement value of a given width
//   - sat_min_neg() : most negative two's-complement value of a given width
// The saturation helpers return 64-bit values; callers cast to their width,
// so widths up to 64 bits are supported.
// -----------------------------------------------------------------------------
package cla_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // A single-chunk configuration still needs a 1-bit counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [63:0] sat_max_pos(input int width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min_neg(input int width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/cla_seq_addsub_if.sv
// -----------------------------------------------------------------------------
// cla_seq_addsub_if
// Request/response bundle of the sequential add/subtract unit.
//   start     : request, sampled only while busy = 0
//   In1, In2  : operands, captured on the accepting edge
//   sub, sat  : operation select and saturation enable, captured with operands
//   busy      : operation in flight
//   done      : one-cycle pulse, Sum and flags valid from this cycle
//   Sum       : result, held until the next done
//   Ov, Cout  : signed overflow / carry out of the unsaturated result
//   Zero      : Sum == 0
// Modports: master (requester, e.g. the ALU) and slave (the arithmetic unit).
// -----------------------------------------------------------------------------
interface cla_seq_addsub_if #(
  parameter int WIDTH = 16
);

  logic             start;
  logic [WIDTH-1:0] In1;
  logic [WIDTH-1:0] In2;
  logic             sub;
  logic             sat;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Sum;
  logic             Ov;
  logic             Cout;
  logic             Zero;

  modport master (
    output start, In1, In2, sub, sat,
    input  busy, done, Sum, Ov, Cout, Zero
  );

  modport slave (
    input  start, In1, In2, sub, sat,
    output busy, done, Sum, Ov, Cout, Zero
  );

endinterface

// File: rtl/cla_chunk.sv
// -----------------------------------------------------------------------------
// cla_chunk
// Combinational CHUNK-bit carry-lookahead adder slice.
//   a, b  : CHUNK-bit addends
//   cin   : carry into bit 0
//   s     : CHUNK-bit sum
//   cout  : carry out of the top bit
//   c_msb : carry into the top bit (overflow detection on the last chunk)
// Every carry is expanded into its flat generate/propagate sum-of-products
// form, so no carry depends on another carry signal.
// -----------------------------------------------------------------------------
module cla_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK-1:0] g;
  logic [CHUNK-1:0] p;
  logic [CHUNK:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // c[i+1] = g[i] | p[i]g[i-1] | p[i]p[i-1]g[i-2] | ... | p[i..0]cin
  always_comb begin
    logic acc;
    logic prop;
    // NOTE: every variable gets a default at the top of the block so that no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    c    = '0;
    acc  = 1'b0;
    prop = 1'b0;
    c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      acc  = g[i];
      prop = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc  = acc | (prop & g[j]);
        prop = prop & p[j];
      end
      c[i+1] = acc | (prop & cin);
    end
  end

  assign s     = p ^ c[CHUNK-1:0];
  assign cout  = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/cla_seq_addsub.sv
// -----------------------------------------------------------------------------
// cla_seq_addsub
// Multi-cycle two's-complement adder/subtractor. A WIDTH-bit operation is
// resolved CHUNK bits per cycle (LSB chunk first) by one reused cla_chunk
// instance, with the inter-chunk carry held in a register. The result either
// wraps or saturates on signed overflow, selected per operation.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous, active-high reset (aborts an operation, no done)
//   bus  : cla_seq_addsub_if.slave (start/In1/In2/sub/sat in,
//          busy/done/Sum/Ov/Cout/Zero out)
//
// Timing: start accepted at edge k -> busy from k+1, chunk i processed at edge
// k+1+i, done pulses in the cycle after edge k+NCHUNK. done is an IDLE cycle,
// so a new start may be accepted then.
//
// Configuration macro CLA_SUB_EN:
//   defined   : sub selects In1-In2 (B inverted, carry-in 1)
//   undefined : add only; sub is ignored, inversion/carry-in logic absent
// -----------------------------------------------------------------------------
module cla_seq_addsub
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic               clk,
  input logic               rst,
  cla_seq_addsub_if.slave   bus
);

  localparam int               NCHUNK  = WIDTH / CHUNK;
  localparam int               CNT_W   = cnt_width(NCHUNK);
  localparam logic [WIDTH-1:0] MAX_POS = WIDTH'(sat_max_pos(WIDTH));
  localparam logic [WIDTH-1:0] MIN_NEG = WIDTH'(sat_min_neg(WIDTH));

  // Control and visible outputs
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             ov_q;
  logic             cout_q;
  logic             zero_q;

  // Operation datapath
  logic [WIDTH-1:0] a_sh;     // A, shifted right one chunk per cycle
  logic [WIDTH-1:0] b_sh;     // B (inverted for subtraction), shifted likewise
  logic             a_msb;    // sign of A, kept for the saturation direction
  logic             carry_q;  // inter-chunk carry
  logic             sat_q;
  logic [WIDTH-1:0] part_q;   // partial sum, chunks shifted in from the top

  // Chunk adder and next-state datapath
  logic [CHUNK-1:0] ch_s;
  logic             ch_cout;
  logic             ch_cmsb;
  logic [WIDTH-1:0] part_next;
  logic [WIDTH-1:0] sum_next;
  logic             ov_next;
  logic             last;
  logic             accept;
  logic [WIDTH-1:0] b_in;
  logic             cin_in;

  cla_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a     (a_sh[CHUNK-1:0]),
    .b     (b_sh[CHUNK-1:0]),
    .cin   (carry_q),
    .s     (ch_s),
    .cout  (ch_cout),
    .c_msb (ch_cmsb)
  );

`ifdef CLA_SUB_EN
  assign b_in   = bus.sub ? ~bus.In2 : bus.In2;
  assign cin_in = bus.sub;
`else
  // sub stays on the interface but carries no meaning in an add-only build.
  logic unused_sub;
  assign unused_sub = bus.sub;
  assign b_in       = bus.In2;
  assign cin_in     = 1'b0;
`endif

  assign accept = (state == IDLE) && bus.start;
  assign last   = (cnt == CNT_W'(NCHUNK - 1));

  // After NCHUNK shifts the first chunk computed sits at the bottom.
  // ov_next and sum_next are only meaningful on the last chunk.
  always_comb begin
    part_next = (part_q >> CHUNK) | (WIDTH'(ch_s) << (WIDTH - CHUNK));
    ov_next   = ch_cmsb ^ ch_cout;
    sum_next  = part_next;
    if (sat_q && ov_next) begin
      sum_next = a_msb ? MIN_NEG : MAX_POS;
    end
  end

  // Controller and visible result registers.
  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sum_q  <= '0;
      ov_q   <= 1'b0;
      cout_q <= 1'b0;
      zero_q <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (last) begin
            sum_q  <= sum_next;
            ov_q   <= ov_next;
            cout_q <= ch_cout;
            zero_q <= (sum_next == '0);
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
      endcase
    end
  end

  // Operand / partial-sum datapath.
  // NOTE: these registers carry no reset: each is loaded on acceptance before
  // it is ever consumed, and the controller alone decides what is visible.
  always_ff @(posedge clk) begin
    if (accept && !rst) begin
      a_sh    <= bus.In1;
      a_msb   <= bus.In1[WIDTH-1];
      b_sh    <= b_in;
      carry_q <= cin_in;
      sat_q   <= bus.sat;
      part_q  <= '0;
    end else if (state == RUN) begin
      a_sh    <= a_sh >> CHUNK;
      b_sh    <= b_sh >> CHUNK;
      carry_q <= ch_cout;
      part_q  <= part_next;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.Sum  = sum_q;
  assign bus.Ov   = ov_q;
  assign bus.Cout = cout_q;
  assign bus.Zero = zero_q;

endmodule

// File: tb/tb_cla_seq_addsub.sv
// -----------------------------------------------------------------------------
// tb_cla_seq_addsub
// Directed bench for cla_seq_addsub (WIDTH=16, CHUNK=4). Stimulus pushes
// hand-computed results into a scoreboard queue; a monitor pops and compares
// on every done pulse. Subtraction vectors expect add-only results when
// CLA_SUB_EN is not defined.
// -----------------------------------------------------------------------------
module tb_cla_seq_addsub;

  localparam int WIDTH  = 16;
  localparam int CHUNK  = 4;
  localparam int NCHUNK = WIDTH / CHUNK;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             ov;
    logic             cout;
    logic             zero;
    string            name;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t sb[$];

  cla_seq_addsub_if #(.WIDTH(WIDTH)) bus ();

  cla_seq_addsub #(
    .WIDTH (WIDTH),
    .CHUNK (CHUNK)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: one scoreboard entry per done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(bus.done), 32'd0);
      end else begin
        e = sb.pop_front();
        check({e.name, ".Sum"},  32'(bus.Sum),  32'(e.sum));
        check({e.name, ".Ov"},   32'(bus.Ov),   32'(e.ov));
        check({e.name, ".Cout"}, 32'(bus.Cout), 32'(e.cout));
        check({e.name, ".Zero"}, 32'(bus.Zero), 32'(e.zero));
      end
    end
  end

  task automatic push_exp(input string name, input logic [WIDTH-1:0] sum,
                          input logic ov, input logic cout);
    exp_t e;
    e.name = name;
    e.sum  = sum;
    e.ov   = ov;
    e.cout = cout;
    e.zero = (sum == '0);
    sb.push_back(e);
  endtask

  // Drive a request for one cycle; returns #1 after the accepting edge with
  // the inputs scrambled (they may change freely once accepted).
  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic s, input logic st);
    @(negedge clk);
    bus.start = 1'b1;
    bus.In1   = a;
    bus.In2   = b;
    bus.sub   = s;
    bus.sat   = st;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.In1   = ~a;
    bus.In2   = ~b;
    bus.sub   = ~s;
    bus.sat   = ~st;
  endtask

  // Called #1 after an edge; counts edges until done is seen (-1 on timeout)
  // and cycles with busy high, including the current one.
  task automatic wait_done(output int edges, output int busy_cycles);
    edges       = -1;
    busy_cycles = int'(bus.busy);
    for (int n = 1; n <= 32; n++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        edges = n;
        break;
      end
      busy_cycles += int'(bus.busy);
    end
  endtask

  task automatic run_op(input string name, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic s, input logic st,
                        input logic [WIDTH-1:0] esum, input logic eov,
                        input logic ecout, output int busy_cycles);
    int edges;
    push_exp(name, esum, eov, ecout);
    start_op(a, b, s, st);
    wait_done(edges, busy_cycles);
    check({name, ".latency"}, 32'(edges), 32'(NCHUNK));
  endtask

  initial begin
    int bc;
    int edges;
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.In1   = '0;
    bus.In2   = '0;
    bus.sub   = 1'b0;
    bus.sat   = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset.busy", 32'(bus.busy), 32'd0);
    check("reset.done", 32'(bus.done), 32'd0);
    check("reset.Sum",  32'(bus.Sum),  32'd0);
    check("reset.Ov",   32'(bus.Ov),   32'd0);
    check("reset.Cout", 32'(bus.Cout), 32'd0);
    check("reset.Zero", 32'(bus.Zero), 32'd1);
    rst = 1'b0;

    // Basic add, latency and busy duration
    run_op("add_0404", 16'h0404, 16'h0404, 1'b0, 1'b1, 16'h0808, 1'b0, 1'b0, bc);
    check("add_0404.busy_cycles", 32'(bc), 32'(NCHUNK));

    // Carry ripples across every chunk boundary
    run_op("add_ripple", 16'h0789, 16'h0987, 1'b0, 1'b0, 16'h1110, 1'b0, 1'b0, bc);

    // Positive overflow: saturate vs wrap
    run_op("pos_ov_sat",  16'h7777, 16'h7777, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b0, bc);
    run_op("pos_ov_wrap", 16'h7777, 16'h7777, 1'b0, 1'b0, 16'hEEEE, 1'b1, 1'b0, bc);

    // Negative overflow: saturate vs wrap
    run_op("neg_ov_sat",  16'h8044, 16'h8044, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1, bc);
    run_op("neg_ov_wrap", 16'h8044, 16'h8044, 1'b0, 1'b0, 16'h0088, 1'b1, 1'b1, bc);

`ifdef CLA_SUB_EN
    run_op("sub_0_1",    16'h0000, 16'h0001, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, bc);
    run_op("sub_min_sat", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1, bc);
    run_op("sub_equal",  16'h1234, 16'h1234, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, bc);
`else
    run_op("sub_0_1",    16'h0000, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, bc);
    run_op("sub_min_sat", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8001, 1'b0, 1'b0, bc);
    run_op("sub_equal",  16'h1234, 16'h1234, 1'b1, 1'b0, 16'h2468, 1'b0, 1'b0, bc);
`endif

    // start pulsed while busy is ignored
    push_exp("ignore", 16'h0808, 1'b0, 1'b0);
    start_op(16'h0404, 16'h0404, 1'b0, 1'b0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.In1   = 16'hFFFF;
    bus.In2   = 16'hFFFF;
    bus.sat   = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(edges, bc);
    check("ignore.latency", 32'(edges), 32'(NCHUNK - 1));
    repeat (8) @(posedge clk);
    #1;
    check("ignore.hold_Sum", 32'(bus.Sum),  32'h0808);
    check("ignore.busy",     32'(bus.busy), 32'd0);

    // start held through the done cycle: back-to-back acceptance
    push_exp("b2b_1", 16'h1110, 1'b0, 1'b0);
    push_exp("b2b_2", 16'h0088, 1'b1, 1'b1);
    @(negedge clk);
    bus.start = 1'b1;
    bus.In1   = 16'h0789;
    bus.In2   = 16'h0987;
    bus.sub   = 1'b0;
    bus.sat   = 1'b0;
    @(posedge clk);
    #1;
    bus.In1 = 16'h8044;
    bus.In2 = 16'h8044;
    wait_done(edges, bc);
    check("b2b_1.latency", 32'(edges), 32'(NCHUNK));
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("b2b_2.accepted", 32'(bus.busy), 32'd1);
    wait_done(edges, bc);
    check("b2b_2.latency", 32'(edges), 32'(NCHUNK));

    // rst after the second chunk aborts without done
    @(negedge clk);
    bus.start = 1'b1;
    bus.In1   = 16'h7777;
    bus.In2   = 16'h7777;
    bus.sat   = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort.busy", 32'(bus.busy), 32'd0);
    check("abort.done", 32'(bus.done), 32'd0);
    check("abort.Sum",  32'(bus.Sum),  32'd0);
    check("abort.Zero", 32'(bus.Zero), 32'd1);
    repeat (8) @(posedge clk);
    #1;
    check("abort.still_idle", 32'(bus.busy), 32'd0);

    // rst wins over a simultaneous start
    @(negedge clk);
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.In1   = 16'h0001;
    bus.In2   = 16'h0001;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    bus.start = 1'b0;
    check("rst_prio.busy", 32'(bus.busy), 32'd0);
    repeat (8) @(posedge clk);
    #1;
    check("rst_prio.no_op", 32'(bus.busy), 32'd0);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
